layer_seq_ctrl: RTL and testbench
=================================

// Module: layer_seq_ctrl
// PURPOSE
//   Top-level sequencer for one convolution layer built around layer_blk.
//   - Preloads the weight BRAMs and the input-FM BRAMs from a shared source memory.
//   - Releases layer_blk from reset and waits for its done flag.
//   - Drains the per-PE output BRAM banks one after another into a downstream consumer.
//   Replaces the free-running bench loaders/readers with one restartable FSM.
// PARAMETERS
//   W_DEPTH        9    weight words per OUT_FM_CH lane (KERNEL_SIZE**2)
//   FM_DEPTH       756  FM words per PE bank (IN_BRAM_SIZE*FM_SIZE)
//   NUM_BANKS      3    output banks to drain (PE_TO_USE)
//   OUT_DEPTH_FIRST 250 words in bank 0 (BRAM_SIZE*OUT_SIZE)
//   OUT_DEPTH_MID  250  words in banks 1..NUM_BANKS-2 (MID_BRAM_SIZE*OUT_SIZE)
//   OUT_DEPTH_LAST 250  words in bank NUM_BANKS-1 (LAST_BRAM_SIZE*OUT_SIZE); bank 0 uses FIRST when NUM_BANKS==1
// PORTS
//   i_clk          in   1     clock, all logic on rising edge
//   i_rst          in   1     asynchronous reset, active-high
//   i_start        in   1     start pulse; sampled only in IDLE
//   o_busy         out  1     high in every state except IDLE
//   o_src_rd_en    out  1     source-memory read strobe (1-cycle read latency)
//   o_src_sel      out  1     0 = weight region, 1 = FM region
//   o_src_rd_addr  out  AW    source read address, AW = $clog2(max(W_DEPTH,FM_DEPTH))+1
//   o_w_wr_en      out  1     weight BRAM write enable
//   o_w_wr_addr    out  $clog2(W_DEPTH)+1  weight BRAM write address
//   o_fm_wr_en     out  1     FM BRAM write enable (all PE/channel banks in parallel)
//   o_fm_wr_addr   out  $clog2(FM_DEPTH)+1 FM BRAM write address
//   o_layer_rst    out  1     reset to layer_blk, active-high
//   i_layer_done   in   1     layer_blk o_done (level or pulse)
//   i_drain_ready  in   1     consumer can accept a new word
//   o_out_rd_addr  out  OW    output BRAM read address, OW = $clog2(max OUT_DEPTH_*)+1
//   o_out_bank     out  $clog2(NUM_BANKS)+1 bank index of the current read
//   o_out_valid    out  1     output BRAM data valid this cycle, for the read issued last cycle
//   o_out_last     out  1     qualifies o_out_valid: final word of final bank
//   o_done         out  1     one-cycle pulse when the drain completes
// BEHAVIOUR
//   Reset values
//   - o_layer_rst = 1; all other outputs 0; FSM = IDLE.
//   FSM: IDLE -> LOAD_W -> LOAD_FM -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE
//   - i_start = 1 -> LOAD_W; index counter cleared.
//   - i_start while busy is ignored.
//   LOAD_W
//   - Each cycle k = 0..W_DEPTH-1: o_src_rd_en = 1, o_src_sel = 0, o_src_rd_addr = k.
//   - Cycle k+1: o_w_wr_en = 1, o_w_wr_addr = k.
//   - After issue k = W_DEPTH-1 -> LOAD_FM with no bubble cycle.
//   - The final weight write lands in the first LOAD_FM cycle.
//   LOAD_FM
//   - Same pattern: o_src_sel = 1, k = 0..FM_DEPTH-1.
//   - o_fm_wr_en / o_fm_wr_addr follow one cycle later.
//   - Leaves for RUN after the last issue.
//   RUN
//   - o_layer_rst drops to 0 on the first RUN cycle, once the final FM write has been issued.
//   - i_layer_done = 1 -> DRAIN.
//   - o_layer_rst returns to 1 on the DRAIN entry edge, so layer_blk restarts cleanly next time.
//   DRAIN
//   - bank b = 0..NUM_BANKS-1, addr a = 0..depth(b)-1.
//   - A read is issued only in cycles with i_drain_ready = 1; otherwise addr and bank hold.
//   - o_out_valid = 1 the cycle after each issue, regardless of i_drain_ready.
//   - The consumer must accept every valid word; i_drain_ready is a one-cycle look-ahead.
//   - Bank switch: after a = depth(b)-1, the next issue is (b+1, 0) with no gap.
//   - After the last issue, wait one cycle for the last valid (o_out_last = 1), then -> DONE.
//   DONE
//   - o_done = 1 for exactly one cycle, then IDLE.
//   - o_out_rd_addr and o_out_bank reset to 0.
//   Asynchronous reset mid-operation
//   - Every state aborts to IDLE with the reset values above.
//   - Partially loaded BRAM contents are don't-care.
//   Counter rules
//   - Counters are unsigned.
//   - Terminal counts are compared against the parameters minus 1, never by wrap.
//   - No address exceeds its depth-1 at any time.
// TESTING
//   (bench params W=9, FM=20, NUM_BANKS=3, depths 4/4/3)
//   1. Reset, then i_start at cycle 0 -> rd_en addr 0..8 sel=0; w_wr_en addr 0..8 one cycle later;
//      fm writes 0..19 follow with no gap; o_layer_rst falls on cycle 30.
//   2. i_layer_done 10 cycles into RUN, ready held 1 -> 11 valid words; bank/addr sequence
//      (0,0..3)(1,0..3)(2,0..2); o_out_last on the 11th; o_done one cycle later.
//   3. Drain with i_drain_ready toggling 1,0,1,0 -> still exactly 11 valid words, same order;
//      each valid follows its issue by 1 cycle.
//   4. i_start re-pulsed during LOAD_FM and DRAIN -> no effect on sequence or counts.
//   5. i_rst asserted in cycle 5 of LOAD_FM -> all outputs at reset values in the same cycle;
//      a new i_start reloads from addr 0.
//   6. NUM_BANKS=1, OUT_DEPTH_FIRST=5 -> 5 valid words from bank 0, o_out_last on the 5th, one o_done.

Source files
------------

// File: rtl/layer_seq_ctrl.sv
// Conv-layer sequencer: preload weights and FMs, run layer_blk, then drain
// its output banks in order. Restartable from IDLE.
module layer_seq_ctrl #(
  parameter int W_DEPTH         = 9,
  parameter int FM_DEPTH        = 756,
  parameter int NUM_BANKS       = 3,
  parameter int OUT_DEPTH_FIRST = 250,
  parameter int OUT_DEPTH_MID   = 250,
  parameter int OUT_DEPTH_LAST  = 250,
  localparam int SRC_MAX = (W_DEPTH > FM_DEPTH) ? W_DEPTH : FM_DEPTH,
  localparam int OD_01   = (OUT_DEPTH_FIRST > OUT_DEPTH_MID) ?
                           OUT_DEPTH_FIRST : OUT_DEPTH_MID,
  localparam int OUT_MAX = (OD_01 > OUT_DEPTH_LAST) ? OD_01 : OUT_DEPTH_LAST,
  localparam int AW  = $clog2(SRC_MAX) + 1,
  localparam int WAW = $clog2(W_DEPTH) + 1,
  localparam int FAW = $clog2(FM_DEPTH) + 1,
  localparam int OW  = $clog2(OUT_MAX) + 1,
  localparam int BW  = $clog2(NUM_BANKS) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_src_rd_en,
  output logic           o_src_sel,
  output logic [AW-1:0]  o_src_rd_addr,
  output logic           o_w_wr_en,
  output logic [WAW-1:0] o_w_wr_addr,
  output logic           o_fm_wr_en,
  output logic [FAW-1:0] o_fm_wr_addr,
  output logic           o_layer_rst,
  input  logic           i_layer_done,
  input  logic           i_drain_ready,
  output logic [OW-1:0]  o_out_rd_addr,
  output logic [BW-1:0]  o_out_bank,
  output logic           o_out_valid,
  output logic           o_out_last,
  output logic           o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_FM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] W_LAST  = AW'(W_DEPTH - 1);
  localparam logic [AW-1:0] FM_LAST = AW'(FM_DEPTH - 1);
  localparam logic [OW-1:0] D_FIRST = OW'(OUT_DEPTH_FIRST - 1);
  localparam logic [OW-1:0] D_MID   = OW'(OUT_DEPTH_MID - 1);
  localparam logic [OW-1:0] D_LAST  = OW'(OUT_DEPTH_LAST - 1);
  localparam logic [BW-1:0] BANK_L  = BW'(NUM_BANKS - 1);

  state_t          state;
  logic            drain_fin;
  logic [OW-1:0]   addr_last;

  // Bank 0 always uses the FIRST depth, even when it is also the last bank.
  always_comb begin
    addr_last = D_MID;
    if (o_out_bank == '0)
      addr_last = D_FIRST;
    else if (o_out_bank == BANK_L)
      addr_last = D_LAST;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      drain_fin     <= 1'b0;
      o_busy        <= 1'b0;
      o_src_rd_en   <= 1'b0;
      o_src_sel     <= 1'b0;
      o_src_rd_addr <= '0;
      o_w_wr_en     <= 1'b0;
      o_w_wr_addr   <= '0;
      o_fm_wr_en    <= 1'b0;
      o_fm_wr_addr  <= '0;
      o_layer_rst   <= 1'b1;
      o_out_rd_addr <= '0;
      o_out_bank    <= '0;
      o_out_valid   <= 1'b0;
      o_out_last    <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_w_wr_en   <= 1'b0;
      o_fm_wr_en  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state         <= S_LOAD_W;
            o_busy        <= 1'b1;
            o_src_rd_en   <= 1'b1;
            o_src_sel     <= 1'b0;
            o_src_rd_addr <= '0;
          end
        end
        S_LOAD_W: begin
          o_w_wr_en   <= 1'b1;
          o_w_wr_addr <= WAW'(o_src_rd_addr);
          if (o_src_rd_addr == W_LAST) begin
            state         <= S_LOAD_FM;
            o_src_sel     <= 1'b1;
            o_src_rd_addr <= '0;
          end else begin
            o_src_rd_addr <= o_src_rd_addr + AW'(1);
          end
        end
        S_LOAD_FM: begin
          o_fm_wr_en   <= 1'b1;
          o_fm_wr_addr <= FAW'(o_src_rd_addr);
          if (o_src_rd_addr == FM_LAST) begin
            state         <= S_RUN;
            o_src_rd_en   <= 1'b0;
            o_src_sel     <= 1'b0;
            o_src_rd_addr <= '0;
            o_layer_rst   <= 1'b0;
          end else begin
            o_src_rd_addr <= o_src_rd_addr + AW'(1);
          end
        end
        S_RUN: begin
          if (i_layer_done) begin
            state       <= S_DRAIN;
            o_layer_rst <= 1'b1;
            drain_fin   <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_fin) begin
            state         <= S_DONE;
            drain_fin     <= 1'b0;
            o_done        <= 1'b1;
            o_out_rd_addr <= '0;
            o_out_bank    <= '0;
          end else if (i_drain_ready) begin
            o_out_valid <= 1'b1;
            if (o_out_rd_addr == addr_last) begin
              if (o_out_bank == BANK_L) begin
                drain_fin  <= 1'b1;
                o_out_last <= 1'b1;
              end else begin
                o_out_bank    <= o_out_bank + BW'(1);
                o_out_rd_addr <= '0;
              end
            end else begin
              o_out_rd_addr <= o_out_rd_addr + OW'(1);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: load table, drain scoreboard, reset abort,
// and a single-bank instance.
module tb_layer_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ldone, rdy;
  logic busy, src_rd_en, src_sel, w_en, fm_en, lrst;
  logic ovalid, olast, odone;
  logic [5:0] src_addr;
  logic [4:0] w_addr;
  logic [5:0] fm_addr;
  logic [2:0] oaddr;
  logic [2:0] obank;

  logic start2, ldone2, rdy2;
  logic busy2, src_rd_en2, src_sel2, w_en2, fm_en2, lrst2;
  logic ovalid2, olast2, odone2;
  logic [5:0] src_addr2;
  logic [4:0] w_addr2;
  logic [5:0] fm_addr2;
  logic [3:0] oaddr2;
  logic [0:0] obank2;

  layer_seq_ctrl #(
    .W_DEPTH(9), .FM_DEPTH(20), .NUM_BANKS(3),
    .OUT_DEPTH_FIRST(4), .OUT_DEPTH_MID(4), .OUT_DEPTH_LAST(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy),
    .o_src_rd_en(src_rd_en), .o_src_sel(src_sel),
    .o_src_rd_addr(src_addr),
    .o_w_wr_en(w_en), .o_w_wr_addr(w_addr),
    .o_fm_wr_en(fm_en), .o_fm_wr_addr(fm_addr),
    .o_layer_rst(lrst), .i_layer_done(ldone),
    .i_drain_ready(rdy), .o_out_rd_addr(oaddr),
    .o_out_bank(obank), .o_out_valid(ovalid),
    .o_out_last(olast), .o_done(odone)
  );

  layer_seq_ctrl #(
    .W_DEPTH(9), .FM_DEPTH(20), .NUM_BANKS(1),
    .OUT_DEPTH_FIRST(5), .OUT_DEPTH_MID(5), .OUT_DEPTH_LAST(5)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2),
    .o_src_rd_en(src_rd_en2), .o_src_sel(src_sel2),
    .o_src_rd_addr(src_addr2),
    .o_w_wr_en(w_en2), .o_w_wr_addr(w_addr2),
    .o_fm_wr_en(fm_en2), .o_fm_wr_addr(fm_addr2),
    .o_layer_rst(lrst2), .i_layer_done(ldone2),
    .i_drain_ready(rdy2), .o_out_rd_addr(oaddr2),
    .o_out_bank(obank2), .o_out_valid(ovalid2),
    .o_out_last(olast2), .o_done(odone2)
  );

  typedef struct {
    logic start;
    logic busy, rd_en, sel;
    int   addr;
    logic w_en;
    int   w_addr;
    logic fm_en;
    int   fm_addr;
    logic lrst;
  } ld_t;

  typedef struct {
    int   cyc;
    logic last;
  } sb_t;

  ld_t ld_tab[32];
  int  eb[11];
  int  ea[11];
  sb_t q[$];
  int  npass = 0;
  int  ntotal = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntotal++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      npass++;
  endtask

  task automatic run_layer(input bit toggle, input bit repulse);
    int n, nvalid, ndone, last_cyc, done_cyc, cyc;
    bit r;
    sb_t e;
    n = 0; nvalid = 0; ndone = 0; last_cyc = -1; done_cyc = -1;
    q.delete();
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, ld_tab[c].busy});
      chk("src_rd_en", {31'd0, src_rd_en}, {31'd0, ld_tab[c].rd_en});
      chk("src_sel", {31'd0, src_sel}, {31'd0, ld_tab[c].sel});
      chk("src_rd_addr", {26'd0, src_addr}, ld_tab[c].addr);
      chk("w_wr_en", {31'd0, w_en}, {31'd0, ld_tab[c].w_en});
      if (ld_tab[c].w_en)
        chk("w_wr_addr", {27'd0, w_addr}, ld_tab[c].w_addr);
      chk("fm_wr_en", {31'd0, fm_en}, {31'd0, ld_tab[c].fm_en});
      if (ld_tab[c].fm_en)
        chk("fm_wr_addr", {26'd0, fm_addr}, ld_tab[c].fm_addr);
      chk("layer_rst", {31'd0, lrst}, {31'd0, ld_tab[c].lrst});
      chk("load out_valid", {31'd0, ovalid}, 0);
      start = ld_tab[c].start | (repulse && c == 15);
    end
    for (int c = 32; c <= 40; c++) begin
      @(negedge clk);
      chk("run layer_rst", {31'd0, lrst}, 0);
      ldone = (c == 40);
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      cyc = 41 + j;
      ldone = 1'b0;
      if (j == 0)
        chk("drain layer_rst", {31'd0, lrst}, 1);
      if (ovalid) begin
        if (q.size() == 0) begin
          chk("spurious valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid latency", cyc, e.cyc + 1);
          chk("out_last", {31'd0, olast}, {31'd0, e.last});
          nvalid++;
          if (e.last) last_cyc = cyc;
        end
      end
      if (odone) begin
        ndone++;
        done_cyc = cyc;
      end
      r = toggle ? (j % 2 == 0) : 1'b1;
      start = repulse && j == 3;
      if (r && n < 11) begin
        chk("rd bank", {29'd0, obank}, eb[n]);
        chk("rd addr", {29'd0, oaddr}, ea[n]);
        q.push_back('{cyc: cyc, last: (n == 10)});
        n++;
      end
      rdy = r;
    end
    rdy = 1'b0;
    start = 1'b0;
    chk("valid count", nvalid, 11);
    chk("done count", ndone, 1);
    chk("queue empty", q.size(), 0);
    chk("done after last", done_cyc, last_cyc + 1);
    chk("idle busy", {31'd0, busy}, 0);
    chk("idle addr", {29'd0, oaddr}, 0);
    chk("idle bank", {29'd0, obank}, 0);
  endtask

  initial begin
    int n, nvalid, ndone, last_cyc, done_cyc;
    sb_t e;
    for (int c = 0; c < 32; c++) begin
      ld_tab[c].start   = (c == 0);
      ld_tab[c].busy    = (c >= 1);
      ld_tab[c].rd_en   = (c >= 1 && c <= 29);
      ld_tab[c].sel     = (c >= 10 && c <= 29);
      ld_tab[c].addr    = (c >= 1 && c <= 9) ? c - 1 :
                          (c >= 10 && c <= 29) ? c - 10 : 0;
      ld_tab[c].w_en    = (c >= 2 && c <= 10);
      ld_tab[c].w_addr  = c - 2;
      ld_tab[c].fm_en   = (c >= 11 && c <= 30);
      ld_tab[c].fm_addr = c - 11;
      ld_tab[c].lrst    = (c < 30);
    end
    for (int k = 0; k < 11; k++) begin
      eb[k] = (k < 4) ? 0 : (k < 8) ? 1 : 2;
      ea[k] = (k < 4) ? k : (k < 8) ? k - 4 : k - 8;
    end

    rst = 1'b1; start = 1'b0; ldone = 1'b0; rdy = 1'b0;
    start2 = 1'b0; ldone2 = 1'b0; rdy2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst layer_rst", {31'd0, lrst}, 1);
    chk("rst src_rd_en", {31'd0, src_rd_en}, 0);
    chk("rst out_valid", {31'd0, ovalid}, 0);
    chk("rst done", {31'd0, odone}, 0);
    rst = 1'b0;

    run_layer(1'b0, 1'b0);
    run_layer(1'b1, 1'b0);
    run_layer(1'b0, 1'b1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre-abort fm_en", {31'd0, fm_en}, 1);
    rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort layer_rst", {31'd0, lrst}, 1);
    chk("abort src_rd_en", {31'd0, src_rd_en}, 0);
    chk("abort src_sel", {31'd0, src_sel}, 0);
    chk("abort src_addr", {26'd0, src_addr}, 0);
    chk("abort fm_en", {31'd0, fm_en}, 0);
    chk("abort w_en", {31'd0, w_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_layer(1'b0, 1'b0);

    n = 0; nvalid = 0; ndone = 0; last_cyc = -1; done_cyc = -1;
    q.delete();
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      ldone2 = (c == 35);
      if (ovalid2) begin
        if (q.size() == 0) begin
          chk("b1 spurious valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("b1 valid latency", c, e.cyc + 1);
          chk("b1 out_last", {31'd0, olast2}, {31'd0, e.last});
          nvalid++;
          if (e.last) last_cyc = c;
        end
      end
      if (odone2) begin
        ndone++;
        done_cyc = c;
      end
      rdy2 = (c >= 36);
      if (c >= 36 && n < 5) begin
        chk("b1 rd bank", {31'd0, obank2}, 0);
        chk("b1 rd addr", {28'd0, oaddr2}, n);
        q.push_back('{cyc: c, last: (n == 4)});
        n++;
      end
    end
    rdy2 = 1'b0;
    chk("b1 valid count", nvalid, 5);
    chk("b1 done count", ndone, 1);
    chk("b1 done after last", done_cyc, last_cyc + 1);
    chk("b1 idle busy", {31'd0, busy2}, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
